// File: rtl/mat_stream_deserializer.sv
// Collects a row-major element stream into a packed M_SIZE x M_SIZE matrix.
// Malformed frames are discarded with a one-cycle err_frame_o pulse.
module mat_stream_deserializer #(
    parameter int D_WIDTH = 8,
    parameter int M_SIZE  = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                s_valid_i,
    output logic                                s_ready_o,
    input  logic [D_WIDTH-1:0]                  s_data_i,
    input  logic                                s_last_i,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [D_WIDTH*M_SIZE*M_SIZE-1:0]    m_matrix_o,
    output logic                                err_frame_o
);

    localparam int N_ELEM = M_SIZE * M_SIZE;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int F_W    = D_WIDTH * N_ELEM;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [F_W-1:0]     buf_q, buf_d;
    logic [F_W-1:0]     out_q, out_d;
    logic               m_valid_q, m_valid_d;
    logic               err_q, err_d;

    logic               elem_xfer;
    logic               frame_xfer;
    logic               at_last;

    assign s_ready_o   = (state_q == ST_FILL);
    assign m_valid_o   = m_valid_q;
    assign m_matrix_o  = out_q;
    assign err_frame_o = err_q;

    assign elem_xfer  = s_valid_i && s_ready_o;
    assign frame_xfer = m_valid_q && m_ready_i;
    assign at_last    = (idx_q == IDX_W'(N_ELEM - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        out_d     = out_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;

        if (frame_xfer) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_FILL: begin
                if (elem_xfer) begin
                    buf_d[int'(idx_q)*D_WIDTH +: D_WIDTH] = s_data_i;
                    if (at_last || s_last_i) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end

                    if (at_last && s_last_i) begin
                        // Output register free (or draining now): take the frame
                        // including the element written this cycle.
                        if (!m_valid_q || m_ready_i) begin
                            out_d     = buf_d;
                            m_valid_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (at_last || s_last_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (frame_xfer) begin
                    out_d     = buf_q;
                    m_valid_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_FILL;
            idx_q     <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    // Assembly buffer needs no reset: every accepted frame rewrites all positions.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_mat_stream_deserializer.sv
// Directed bench for mat_stream_deserializer at D_WIDTH=8, M_SIZE=2.
module tb_mat_stream_deserializer;

    localparam int DW = 8;
    localparam int MS = 2;
    localparam int FW = DW * MS * MS;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i;
    logic          s_last_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [FW-1:0] m_matrix_o;
    logic          err_frame_o;

    int n_cmp = 0;
    int n_bad = 0;

    mat_stream_deserializer #(.D_WIDTH(DW), .M_SIZE(MS)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_matrix_o  (m_matrix_o),
        .err_frame_o (err_frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one element for one edge; s_valid_i is left high afterwards.
    task automatic send(input logic [DW-1:0] d, input logic l);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        tick();
    endtask

    task automatic idle();
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        tick();
    endtask

    initial begin
        reset_i   = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;

        check("rst_s_ready", 64'(s_ready_o), 64'd1);
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_matrix", 64'(m_matrix_o), 64'd0);
        check("rst_err", 64'(err_frame_o), 64'd0);

        // Basic frame, output register free
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h21, 1'b0);
        check("basic_no_early_valid", 64'(m_valid_o), 64'd0);
        send(8'h22, 1'b1);
        check("basic_m_valid", 64'(m_valid_o), 64'd1);
        check("basic_matrix", 64'(m_matrix_o), 64'h22211211);
        check("basic_err", 64'(err_frame_o), 64'd0);
        idle();
        check("basic_drain", 64'(m_valid_o), 64'd0);

        // Backpressure: A held, B waits in the assembly buffer
        m_ready_i = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        check("bp_a_valid", 64'(m_valid_o), 64'd1);
        check("bp_a_matrix", 64'(m_matrix_o), 64'h04030201);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        check("bp_a_stable", 64'(m_matrix_o), 64'h04030201);
        send(8'h07, 1'b0);
        send(8'h08, 1'b1);
        check("bp_wait_s_ready", 64'(s_ready_o), 64'd0);
        check("bp_wait_matrix", 64'(m_matrix_o), 64'h04030201);
        check("bp_wait_valid", 64'(m_valid_o), 64'd1);
        send(8'hEE, 1'b1);
        check("bp_ignored_err", 64'(err_frame_o), 64'd0);
        check("bp_ignored_ready", 64'(s_ready_o), 64'd0);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        check("bp_b_matrix", 64'(m_matrix_o), 64'h08070605);
        check("bp_b_valid", 64'(m_valid_o), 64'd1);
        check("bp_b_s_ready", 64'(s_ready_o), 64'd1);
        tick();
        check("bp_b_held", 64'(m_matrix_o), 64'h08070605);
        m_ready_i = 1'b1;
        tick();
        check("bp_b_drain", 64'(m_valid_o), 64'd0);

        // Back-to-back frames with s_valid held
        begin
            logic [DW-1:0] stim[8];
            logic          exp_v[8];
            stim  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
            exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 8; i++) begin
                send(stim[i], (i % 4) == 3);
                check($sformatf("b2b_s_ready_%0d", i), 64'(s_ready_o), 64'd1);
                check($sformatf("b2b_m_valid_%0d", i), 64'(m_valid_o), 64'(exp_v[i]));
                if (i == 3) check("b2b_matrix_0", 64'(m_matrix_o), 64'h34333231);
                if (i == 7) check("b2b_matrix_1", 64'(m_matrix_o), 64'h44434241);
            end
        end
        idle();
        check("b2b_drain", 64'(m_valid_o), 64'd0);

        // Early last
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        check("early_err", 64'(err_frame_o), 64'd1);
        check("early_m_valid", 64'(m_valid_o), 64'd0);
        idle();
        check("early_err_clear", 64'(err_frame_o), 64'd0);
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        send(8'h54, 1'b1);
        check("early_next_valid", 64'(m_valid_o), 64'd1);
        check("early_next_matrix", 64'(m_matrix_o), 64'h54535251);

        // Missing last while a good frame is held
        m_ready_i = 1'b0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        send(8'h64, 1'b0);
        check("miss_err", 64'(err_frame_o), 64'd1);
        check("miss_m_valid", 64'(m_valid_o), 64'd1);
        check("miss_matrix", 64'(m_matrix_o), 64'h54535251);
        check("miss_s_ready", 64'(s_ready_o), 64'd1);
        idle();
        check("miss_err_clear", 64'(err_frame_o), 64'd0);
        m_ready_i = 1'b1;
        idle();
        check("miss_drain", 64'(m_valid_o), 64'd0);

        // Reset mid-frame
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        s_valid_i = 1'b0;
        reset_i   = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid_rst_m_valid", 64'(m_valid_o), 64'd0);
        check("mid_rst_matrix", 64'(m_matrix_o), 64'd0);
        check("mid_rst_err", 64'(err_frame_o), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready_o), 64'd1);
        send(8'h81, 1'b0);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b1);
        check("post_rst_valid", 64'(m_valid_o), 64'd1);
        check("post_rst_matrix", 64'(m_matrix_o), 64'h84838281);
        check("post_rst_err", 64'(err_frame_o), 64'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_stream_deserializer.md
MAT_STREAM_DESERIALIZER -- requirements
Module: mat_stream_deserializer

Interface
REQ-001 Parameter D_WIDTH, default 8: element width in bits.
REQ-002 Parameter M_SIZE, default 4: matrix dimension; a frame is M_SIZE*M_SIZE elements.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 s_ready  output  1  block can accept an element this cycle.
REQ-007 s_data  input  D_WIDTH  element value; row-major order, (0,0) first.
REQ-008 s_last  input  1  marks the final element of a frame.
REQ-009 m_valid  output  1  m_matrix holds a complete frame.
REQ-010 m_ready  input  1  downstream accepts the frame.
REQ-011 m_matrix  output  D_WIDTH*M_SIZE*M_SIZE  packed frame; element (i,j) at bits [(i*M_SIZE+j)*D_WIDTH +: D_WIDTH].
REQ-012 err_frame  output  1  one-cycle pulse flagging a discarded malformed frame.

Function
REQ-013 An element transfer occurs on any rising edge with s_valid=1 and s_ready=1; a frame transfer occurs on any rising edge with m_valid=1 and m_ready=1.
REQ-014 The block holds an element index idx (0..M_SIZE*M_SIZE-1), an assembly buffer, an output register driving m_matrix, and a two-state FSM: FILL and WAIT.
REQ-015 FILL: s_ready=1; each accepted element is written to assembly position idx, and idx increments.
REQ-016 Frame completion: the element accepted at idx=M_SIZE*M_SIZE-1 with s_last=1 completes the frame; idx returns to 0.
REQ-017 On completion, if m_valid=0 or a frame transfer occurs at the same edge, the output register loads the full frame (including the completing element) at that edge; m_valid=1 from the next cycle; FSM stays in FILL.
REQ-018 On completion with m_valid=1 and m_ready=0, FSM enters WAIT.
REQ-019 WAIT: s_ready=0; on the next frame transfer, the output register loads the assembly buffer at that edge, m_valid stays 1, and FSM returns to FILL.
REQ-020 Latency: m_valid rises one cycle after the completing element transfer when the output register is free.
REQ-021 Throughput: with m_ready held at 1, frames may arrive back-to-back with no idle cycle on s_ready.
REQ-022 m_valid falls after a frame transfer only when no new frame loads at the same edge; m_matrix is stable while m_valid=1 and m_ready=0.
REQ-023 Early last: s_last=1 accepted at idx<M_SIZE*M_SIZE-1 discards the partial frame, sets idx to 0, and pulses err_frame for exactly the next cycle; m_valid and m_matrix are unaffected.
REQ-024 Missing last: s_last=0 accepted at idx=M_SIZE*M_SIZE-1 discards the frame, sets idx to 0, and pulses err_frame for the next cycle; m_valid and m_matrix are unaffected.
REQ-025 A discarded frame never enters WAIT and never alters the output register.
REQ-026 s_data and s_last are ignored whenever s_valid=0 or s_ready=0.
REQ-027 Assembly positions are not cleared between frames; every valid frame overwrites all positions.

Reset
REQ-028 While reset=1 at a rising edge: FSM=FILL, idx=0, m_valid=0, m_matrix=0, err_frame=0; assembly buffer contents are don't-care.
REQ-029 s_ready=1 in the first cycle after reset deasserts.
REQ-030 Reset mid-frame or in WAIT discards all pending data and raises no err_frame.

Verification (D_WIDTH=8, M_SIZE=2)
REQ-031 Stream 0x11,0x12,0x21,0x22 (s_last on 4th), m_ready=1 -> m_valid=1 next cycle, m_matrix=32'h22211211, err_frame stays 0.
REQ-032 m_ready=0; send frame A (0x01..0x04), then frame B (0x05..0x08) -> after B completes, s_ready=0 and m_matrix holds A; raise m_ready for one cycle -> m_matrix=32'h08070605, m_valid stays 1, s_ready=1.
REQ-033 Two frames back-to-back with m_ready=1 and s_valid held 1 -> s_ready never drops, and m_valid shows each frame in turn one cycle after its last element.
REQ-034 Send 0xAA,0xBB with s_last on 2nd -> err_frame=1 for one cycle, no m_valid; next well-formed frame is assembled correctly from idx 0.
REQ-035 Send 4 elements with s_last=0 -> err_frame pulse, no m_valid; send 2 elements then reset=1 -> m_valid=0, m_matrix=0, err_frame=0, and the next frame assembles from idx 0.
